fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Front end of the CPU, directly upstream of the control FSM: owns the program counter (PC) and instruction register (IR).
- Runs the instruction-memory read handshake when the FSM is in its fetch state.
- Decodes the IR into the opcode / isaluop / field outputs that the FSM and datapath consume.
- Updates the PC (sequential, jump, branch) when the FSM is in its next-instruction state.

Parameters:
- WORD_SIZE, 16, instruction/data word width
- NIB_SIZE, 4, opcode and register-field width
- RESET_VECTOR, 16'h0000, PC value after reset or do_reset
- TIMEOUT, 15, max cycles to wait for mem_ack before faulting (1..255)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- do_fetch  input  1  FSM in fetch state
- do_next  input  1  FSM in next-instruction state
- do_reset  input  1  FSM in reset state (synchronous soft reset)
- jump_target  input  WORD_SIZE  absolute target for OP_JMP (register-file read data)
- br_taken  input  1  branch condition for OP_BR, sampled with do_next
- mem_req  output  1  instruction read request
- mem_addr  output  WORD_SIZE  read address (= pc)
- mem_rdata  input  WORD_SIZE  read data, valid with mem_ack
- mem_ack  input  1  read complete
- busy  output  1  fetch in flight; stalls the FSM
- fault  output  1  sticky fetch-timeout flag
- pc  output  WORD_SIZE  current program counter
- ir  output  WORD_SIZE  latched instruction
- opcode  output  NIB_SIZE  ir[15:12]
- isaluop  output  1  ~ir[15] (opcodes 0–7 are ALU ops)
- rd, rs1, rs2  output  NIB_SIZE each  ir[11:8], ir[7:4], ir[3:0]
- imm8  output  8  ir[7:0]

Behaviour:
- Reset (async, rst_n low):
  - pc=RESET_VECTOR, ir=0, mem_req=0, busy=0, fault=0, FSM=IDLE, timeout counter=0.
- Non-ALU opcodes:
  - LOAD=8, STORE=9, LOADLO=10, LOADHI=11, IN=12, OUT=13, JMP=14, BR=15.
- Decode outputs are combinational from ir.
- Internal FSM, states IDLE and BUSY:
  - IDLE -> BUSY on do_fetch. mem_req=1 and busy=1 from the next cycle.
  - mem_addr=pc at all times; it is stable through BUSY because the PC does not change while busy.
  - BUSY, mem_ack=1: ir<=mem_rdata, mem_req<=0, counter<=0, -> IDLE.
    - Minimum latency is 2 edges: do_fetch edge, then ack edge. ack is only sampled in BUSY.
  - BUSY, no ack: counter increments.
    - When counter reaches TIMEOUT-1 with no ack: fault<=1, ir unchanged, mem_req<=0, -> IDLE.
    - ack arriving on that same edge wins: normal completion, no fault.
  - mem_ack in IDLE is ignored.
  - do_fetch while BUSY is ignored (no re-issue).
- PC update on do_next in IDLE, decided on the current opcode:
  - OP_JMP: pc<=jump_target.
  - OP_BR with br_taken=1: pc<=pc+1+sign_extend(imm8).
  - OP_BR with br_taken=0, and all other opcodes: pc<=pc+1.
  - All arithmetic is modulo 2^WORD_SIZE (wraps FFFF->0000; backward branches wrap below 0).
- do_next while BUSY is ignored; pc is unchanged.
- do_reset, synchronous: same effect as rst_n except the memory side.
  - Aborts any in-flight fetch: mem_req<=0, -> IDLE.
  - Clears fault.
  - Has priority over do_fetch, do_next and mem_ack on the same edge.
- do_fetch and do_next asserted together in IDLE (illegal from the FSM): do_next applies, fetch is ignored.
- rst_n asserted mid-fetch: mem_req drops immediately (asynchronously); a late ack after release is ignored (IDLE).

Test Plan:
- Reset then fetch: rst_n low->high, do_fetch pulse, mem_rdata=16'h8123 with ack 3 cycles later -> mem_req high 3 cycles, mem_addr=0000; then ir=8123, opcode=8, isaluop=0, rd=1, rs1=2, rs2=3, busy=0.
- Sequential and wrap: ir=16'h1234 (ALU op, isaluop=1), pc=FFFF, do_next -> pc=0000.
- Jump and branch:
  - pc=0010, ir=E000, jump_target=0400, do_next -> pc=0400.
  - pc=0010, ir=F0FE, br_taken=1 -> pc=000F.
  - Same, br_taken=0 -> pc=0011.
- Timeout: TIMEOUT=15, do_fetch, no ack -> mem_req drops after 15 BUSY cycles, fault=1, ir unchanged.
  - Then do_reset -> fault=0, pc=RESET_VECTOR.
  - Corner: ack exactly on the final cycle -> ir loaded, fault=0.
- Abort and ignored inputs:
  - do_fetch, then do_reset while BUSY -> mem_req=0 next cycle, IDLE, ir=0.
  - Subsequent stray mem_ack -> no change.
  - do_next while BUSY -> pc unchanged.
- Async reset mid-fetch: rst_n low while BUSY -> mem_req and busy drop without a clock edge; all outputs at reset values.

Source files
------------

// File: rtl/fetch_unit.sv
// Purpose: owns the PC and IR, runs the instruction-memory read and decodes the IR.
// Latency: a fetch takes at least 2 edges (do_fetch edge, then ack edge); the PC update takes 1 edge.
// Backpressure: busy stalls the FSM while a read is in flight; a missing ack times out and sets a sticky fault.
module fetch_unit #(
  parameter int                    WORD_SIZE    = 16,
  parameter int                    NIB_SIZE     = 4,
  parameter logic [WORD_SIZE-1:0]  RESET_VECTOR = 16'h0000,
  parameter int                    TIMEOUT      = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 do_fetch,
  input  logic                 do_next,
  input  logic                 do_reset,
  input  logic [WORD_SIZE-1:0] jump_target,
  input  logic                 br_taken,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  output logic                 busy,
  output logic                 fault,
  output logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] ir,
  output logic [NIB_SIZE-1:0]  opcode,
  output logic                 isaluop,
  output logic [NIB_SIZE-1:0]  rd,
  output logic [NIB_SIZE-1:0]  rs1,
  output logic [NIB_SIZE-1:0]  rs2,
  output logic [7:0]           imm8
);

  localparam logic       ST_IDLE = 1'b0;
  localparam logic       ST_BUSY = 1'b1;

  // Only the control-flow opcodes matter here; 8..13 are loads/stores/IO and
  // simply advance the PC like ALU ops (0..7).
  localparam logic [NIB_SIZE-1:0] OP_JMP = 4'd14;
  localparam logic [NIB_SIZE-1:0] OP_BR  = 4'd15;

  // Last count value of a BUSY stretch before the read is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic                 state;
  logic [7:0]           cnt;
  logic [WORD_SIZE-1:0] pc_next;
  logic [WORD_SIZE-1:0] br_offset;

  // The request is exactly the BUSY state, so an async reset drops it at once.
  assign mem_req  = (state == ST_BUSY);
  assign busy     = (state == ST_BUSY);
  assign mem_addr = pc;

  assign opcode  = ir[WORD_SIZE-1 -: NIB_SIZE];
  assign isaluop = ~ir[WORD_SIZE-1];
  assign rd      = ir[3*NIB_SIZE-1 -: NIB_SIZE];
  assign rs1     = ir[2*NIB_SIZE-1 -: NIB_SIZE];
  assign rs2     = ir[NIB_SIZE-1:0];
  assign imm8    = ir[7:0];

  assign br_offset = {{(WORD_SIZE-8){ir[7]}}, ir[7:0]};

  // Next-PC selection from the current opcode; all sums wrap modulo 2^WORD_SIZE.
  always_comb begin
    pc_next = pc + 1'b1;
    if (opcode == OP_JMP) begin
      pc_next = jump_target;
    end else if (opcode == OP_BR && br_taken) begin
      pc_next = pc + 1'b1 + br_offset;
    end
  end

  // Fetch FSM, timeout counter, IR capture and sticky fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ir    <= '0;
      fault <= 1'b0;
    end else if (do_reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ir    <= '0;
      fault <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          // A simultaneous do_next wins; the fetch is dropped.
          if (do_fetch && !do_next) begin
            state <= ST_BUSY;
          end
        end
        default: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            cnt   <= '0;
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            fault <= 1'b1;
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // PC advances only on do_next in IDLE, keeping mem_addr stable during a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VECTOR;
    end else if (do_reset) begin
      pc <= RESET_VECTOR;
    end else if (state == ST_IDLE && do_next) begin
      pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of PC-update/decode vectors plus
// hand-written sequences for reset, timeout, abort and async-reset corners.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        do_fetch, do_next, do_reset;
  logic [15:0] jump_target;
  logic        br_taken;
  logic        mem_req;
  logic [15:0] mem_addr, mem_rdata;
  logic        mem_ack;
  logic        busy, fault;
  logic [15:0] pc, ir;
  logic [3:0]  opcode, rd, rs1, rs2;
  logic        isaluop;
  logic [7:0]  imm8;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .do_fetch(do_fetch), .do_next(do_next),
    .do_reset(do_reset), .jump_target(jump_target), .br_taken(br_taken),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .busy(busy), .fault(fault), .pc(pc), .ir(ir),
    .opcode(opcode), .isaluop(isaluop), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm8(imm8)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] start_pc;
    logic [15:0] instr;
    logic [15:0] jt;
    logic        br;
    logic [15:0] exp_pc;
    logic [3:0]  exp_op;
    logic        exp_alu;
    logic [3:0]  exp_rd;
    logic [3:0]  exp_rs1;
    logic [3:0]  exp_rs2;
    logic [7:0]  exp_imm;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // do_fetch pulse, ack arrives dly edges after the fetch edge.
  task automatic fetch(input logic [15:0] data, input int dly);
    do_fetch = 1'b1;
    tick();
    do_fetch = 1'b0;
    repeat (dly - 1) tick();
    mem_ack   = 1'b1;
    mem_rdata = data;
    tick();
    mem_ack   = 1'b0;
  endtask

  task automatic next(input logic [15:0] jt, input logic br);
    do_next     = 1'b1;
    jump_target = jt;
    br_taken    = br;
    tick();
    do_next  = 1'b0;
    br_taken = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{16'hFFFF, 16'h1234, 16'h0000, 1'b0, 16'h0000, 4'h1, 1'b1, 4'h2, 4'h3, 4'h4, 8'h34};
    vecs[1] = '{16'h0010, 16'hE000, 16'h0400, 1'b0, 16'h0400, 4'hE, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00};
    vecs[2] = '{16'h0010, 16'hF0FE, 16'h0000, 1'b1, 16'h000F, 4'hF, 1'b0, 4'h0, 4'hF, 4'hE, 8'hFE};
    vecs[3] = '{16'h0010, 16'hF0FE, 16'h0000, 1'b0, 16'h0011, 4'hF, 1'b0, 4'h0, 4'hF, 4'hE, 8'hFE};
    vecs[4] = '{16'h0000, 16'hF080, 16'h0000, 1'b1, 16'hFF81, 4'hF, 1'b0, 4'h0, 4'h8, 4'h0, 8'h80};
    vecs[5] = '{16'h7FF0, 16'hF07F, 16'h0000, 1'b1, 16'h8070, 4'hF, 1'b0, 4'h0, 4'h7, 4'hF, 8'h7F};
    vecs[6] = '{16'h1234, 16'h8123, 16'h5555, 1'b1, 16'h1235, 4'h8, 1'b0, 4'h1, 4'h2, 4'h3, 8'h23};
    vecs[7] = '{16'h00FF, 16'h7ABC, 16'h0000, 1'b1, 16'h0100, 4'h7, 1'b1, 4'hA, 4'hB, 4'hC, 8'hBC};
    vecs[8] = '{16'hABCD, 16'hEFFF, 16'h0000, 1'b0, 16'h0000, 4'hE, 1'b0, 4'hF, 4'hF, 4'hF, 8'hFF};

    rst_n = 1'b0; do_fetch = 1'b0; do_next = 1'b0; do_reset = 1'b0;
    jump_target = '0; br_taken = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    #12;
    check("rst pc", pc, 16'h0000);
    check("rst ir", ir, 16'h0000);
    check("rst mem_req", mem_req, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst fault", fault, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // First fetch: request held 3 cycles at address 0, ack on the third edge.
    do_fetch = 1'b1;
    tick();
    do_fetch = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("f0 mem_req c%0d", k), mem_req, 1'b1);
      check($sformatf("f0 busy c%0d", k), busy, 1'b1);
      check($sformatf("f0 mem_addr c%0d", k), mem_addr, 16'h0000);
      if (k == 2) begin
        mem_ack = 1'b1;
        mem_rdata = 16'h8123;
      end
      tick();
    end
    mem_ack = 1'b0;
    check("f0 mem_req done", mem_req, 1'b0);
    check("f0 busy done", busy, 1'b0);
    check("f0 ir", ir, 16'h8123);
    check("f0 opcode", opcode, 4'h8);
    check("f0 isaluop", isaluop, 1'b0);
    check("f0 rd", rd, 4'h1);
    check("f0 rs1", rs1, 4'h2);
    check("f0 rs2", rs2, 4'h3);

    // Table: reach start_pc via a jump, fetch the instruction, apply do_next.
    for (int i = 0; i < 9; i++) begin
      fetch(16'hE000, 2);
      next(vecs[i].start_pc, 1'b0);
      check($sformatf("v%0d start pc", i), pc, vecs[i].start_pc);
      fetch(vecs[i].instr, 1 + (i % 3));
      check($sformatf("v%0d ir", i), ir, vecs[i].instr);
      check($sformatf("v%0d opcode", i), opcode, vecs[i].exp_op);
      check($sformatf("v%0d isaluop", i), isaluop, vecs[i].exp_alu);
      check($sformatf("v%0d rd", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d rs1", i), rs1, vecs[i].exp_rs1);
      check($sformatf("v%0d rs2", i), rs2, vecs[i].exp_rs2);
      check($sformatf("v%0d imm8", i), imm8, vecs[i].exp_imm);
      next(vecs[i].jt, vecs[i].br);
      check($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
    end

    // Timeout: no ack, request held for exactly 15 cycles.
    do_fetch = 1'b1;
    tick();
    do_fetch = 1'b0;
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      tick();
    end
    check("timeout cycles", 16'(n), 16'd15);
    check("timeout fault", fault, 1'b1);
    check("timeout ir kept", ir, 16'hEFFF);
    check("timeout busy", busy, 1'b0);
    // Stray ack in IDLE must not load the IR.
    mem_ack = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_ack = 1'b0;
    check("idle ack ignored", ir, 16'hEFFF);
    check("fault sticky", fault, 1'b1);
    do_reset = 1'b1;
    tick();
    do_reset = 1'b0;
    check("soft rst fault", fault, 1'b0);
    check("soft rst pc", pc, 16'h0000);
    check("soft rst ir", ir, 16'h0000);

    // Ack on the last allowed edge wins over the timeout.
    fetch(16'h4321, 15);
    check("late ack ir", ir, 16'h4321);
    check("late ack fault", fault, 1'b0);
    check("late ack busy", busy, 1'b0);
    // One edge later is too late.
    fetch(16'h9999, 16);
    check("too late ir", ir, 16'h4321);
    check("too late fault", fault, 1'b1);

    // Abort an in-flight fetch with do_reset.
    do_fetch = 1'b1;
    tick();
    do_fetch = 1'b0;
    tick();
    do_reset = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    do_reset = 1'b0; mem_ack = 1'b0;
    check("abort mem_req", mem_req, 1'b0);
    check("abort busy", busy, 1'b0);
    check("abort ir", ir, 16'h0000);
    check("abort fault", fault, 1'b0);
    mem_ack = 1'b1; mem_rdata = 16'h6666;
    tick();
    mem_ack = 1'b0;
    check("stray ack ir", ir, 16'h0000);
    check("stray ack busy", busy, 1'b0);

    // do_next while BUSY leaves the PC alone; do_fetch while BUSY is ignored.
    do_fetch = 1'b1;
    tick();
    do_next = 1'b1;
    tick();
    do_next = 1'b0; do_fetch = 1'b0;
    check("busy next pc", pc, 16'h0000);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    check("busy next ir", ir, 16'h1111);
    check("busy next done", busy, 1'b0);

    // do_fetch with do_next in IDLE: PC advances, no fetch starts.
    do_fetch = 1'b1; do_next = 1'b1;
    tick();
    do_fetch = 1'b0; do_next = 1'b0;
    check("both pc", pc, 16'h0001);
    check("both busy", busy, 1'b0);

    // Async reset mid-fetch drops request without an edge.
    do_fetch = 1'b1;
    tick();
    do_fetch = 1'b0;
    check("pre arst busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst mem_req", mem_req, 1'b0);
    check("arst busy", busy, 1'b0);
    check("arst pc", pc, 16'h0000);
    check("arst ir", ir, 16'h0000);
    check("arst fault", fault, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'h2222;
    tick();
    mem_ack = 1'b0;
    check("post arst ack ir", ir, 16'h0000);
    check("post arst busy", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
